instr_encoder_loader: RTL and testbench

Sequential instruction encoder and program loader that fills the 16-bit instruction memory of the single-cycle processor before execution. It accepts decoded instruction fields (opcode, rs, rt, rd, imm) over a valid/ready handshake, packs them into the instruction word format that the control decoder consumes, and writes the words to consecutive instruction-memory addresses. It sits between the testbench or boot source and the instruction memory write port. It is active only while the core is held off; `loadDone` releases it.

---
 rtl/instr_encoder_loader.sv | 129 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words and streams them into instruction memory.
// Optional ILLEGAL_OP_TRAP_EN: illegal opcodes are consumed without writing and raise sticky illegalOp.
module instr_encoder_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              loadStart,
    input  logic              inValid,
    output logic              inReady,
    input  logic              inLast,
    input  logic [3:0]        opCode,
    input  logic [3:0]        rs,
    input  logic [3:0]        rt,
    input  logic [3:0]        rd,
    input  logic [3:0]        imm,
    output logic              imemWe,
    output logic [ADDR_W-1:0] imemAddr,
    output logic [15:0]       imemWData,
    output logic [ADDR_W:0]   wordCount,
    output logic              loadDone,
    output logic              illegalOp
);

    localparam logic [ADDR_W:0] CAP      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                inReady_q, inReady_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;

    logic                accept, do_write, fill, start;
    logic [15:0]         encoded;

    assign start   = (state_q == S_IDLE) && loadStart;
    assign accept  = inValid && inReady_q;
    assign encoded = opCode[3] ? {opCode, rs, rt, imm} : {opCode, rs, rt, rd};

`ifdef ILLEGAL_OP_TRAP_EN
    logic legal;
    logic illegal_q;

    always_comb begin
        legal = 1'b0;
        case (opCode)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd10, 4'd14: legal = 1'b1;
            default:                                          legal = 1'b0;
        endcase
    end

    assign do_write = accept && legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 illegal_q <= 1'b0;
        else if (start)            illegal_q <= 1'b0;
        else if (accept && !legal) illegal_q <= 1'b1;
    end

    assign illegalOp = illegal_q;
`else
    assign do_write  = accept;
    assign illegalOp = 1'b0;
`endif

    // A write landing on the last address closes the session even without inLast.
    assign fill = do_write && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (loadStart) state_d = S_LOAD;
            S_LOAD:  if (accept && (inLast || fill)) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = do_write;
        if (start) begin
            cnt_d  = '0;
            addr_d = '0;
        end else if (do_write) begin
            cnt_d   = cnt_q + ONE;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = encoded;
        end
        inReady_d = (state_d == S_LOAD) && (cnt_d < CAP);
        loadDone  = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inReady_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            inReady_q <= inReady_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
        end
    end

    assign inReady   = inReady_q;
    assign imemWe    = we_q;
    assign imemAddr  = addr_q;
    assign imemWData = wdata_q;
    assign wordCount = cnt_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized session bench for instr_encoder_loader against a transaction-level program model.
module tb_instr_encoder_loader;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, loadStart, inValid, inLast;
    logic [3:0]    opCode, rs, rt, rd, imm;
    logic          inReady, imemWe, loadDone, illegalOp;
    logic [AW-1:0] imemAddr;
    logic [15:0]   imemWData;
    logic [AW:0]   wordCount;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] op, rs, rt, rd, imm;
        logic       last;
    } item_t;

    item_t items[$];

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .loadStart(loadStart), .inValid(inValid),
        .inReady(inReady), .inLast(inLast), .opCode(opCode), .rs(rs), .rt(rt),
        .rd(rd), .imm(imm), .imemWe(imemWe), .imemAddr(imemAddr),
        .imemWData(imemWData), .wordCount(wordCount), .loadDone(loadDone),
        .illegalOp(illegalOp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd10, 4'd14};
    endfunction

    function automatic bit writes(input item_t it);
`ifdef ILLEGAL_OP_TRAP_EN
        return is_legal(it.op);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [15:0] enc(input item_t it);
        return it.op[3] ? {it.op, it.rs, it.rt, it.imm} : {it.op, it.rs, it.rt, it.rd};
    endfunction

    function automatic item_t mk(input logic [3:0] op, rs_, rt_, rd_, imm_, input bit last);
        item_t it;
        it.op = op; it.rs = rs_; it.rt = rt_; it.rd = rd_; it.imm = imm_; it.last = last;
        return it;
    endfunction

    // Runs one load session over the queued items; dense forces inValid every cycle.
    task automatic run_session(input bit dense, input bit poke);
        int  k_end, nw, idx, wcount, done_in, cycles, addr_e;
        bit  closed, exp_we, ill;
        logic [15:0] data_e;
        k_end = items.size() - 1;
        nw = 0;
        for (int i = 0; i < items.size(); i++) begin
            if (writes(items[i])) nw++;
            if (items[i].last || nw == CAP) begin
                k_end = i;
                break;
            end
        end
        ill = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i <= k_end; i++) if (!is_legal(items[i].op)) ill = 1'b1;
`endif
        @(negedge clk);
        chk("idle_rdy", inReady, 1'b0);
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
        idx = 0; wcount = 0; done_in = -1; cycles = 0;
        closed = 1'b0; exp_we = 1'b0; addr_e = 0; data_e = '0;
        forever begin
            chk("rdy", inReady, !closed);
            chk("we", imemWe, exp_we);
            if (exp_we) begin
                chk("addr", imemAddr, addr_e);
                chk("data", imemWData, data_e);
                chk("wcnt_wr", wordCount, wcount);
            end
            chk("done", loadDone, done_in == 0);
            if (done_in == 0) begin
                inValid = 1'b0;
                @(negedge clk);
                chk("done_once", loadDone, 1'b0);
                chk("rdy_end", inReady, 1'b0);
                chk("wcnt_end", wordCount, wcount);
                chk("illegal", illegalOp, ill);
                return;
            end
            if (done_in > 0) done_in--;
            exp_we    = 1'b0;
            inValid   = (idx < items.size()) && (dense || $urandom_range(3) != 0);
            loadStart = poke && !closed && ($urandom_range(3) == 0);
            if (inValid) begin
                opCode = items[idx].op; rs = items[idx].rs; rt = items[idx].rt;
                rd = items[idx].rd; imm = items[idx].imm; inLast = items[idx].last;
            end else begin
                opCode = 4'($urandom); rs = 4'($urandom); rt = 4'($urandom);
                rd = 4'($urandom); imm = 4'($urandom); inLast = 1'($urandom);
            end
            if (inValid && !closed) begin
                if (writes(items[idx])) begin
                    exp_we = 1'b1;
                    addr_e = wcount;
                    data_e = enc(items[idx]);
                    wcount++;
                end
                if (idx == k_end) begin
                    closed  = 1'b1;
                    done_in = 1;
                end
                idx++;
            end
            @(negedge clk);
            loadStart = 1'b0;
            cycles++;
            if (cycles > 200) begin
                chk("timeout", 1'b1, 1'b0);
                inValid = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        reset = 1'b1; loadStart = 1'b0; inValid = 1'b0; inLast = 1'b0;
        opCode = '0; rs = '0; rt = '0; rd = '0; imm = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", inReady, 1'b0);
        chk("rst_we", imemWe, 1'b0);
        chk("rst_addr", imemAddr, 0);
        chk("rst_data", imemWData, 0);
        chk("rst_wcnt", wordCount, 0);
        chk("rst_done", loadDone, 1'b0);
        chk("rst_ill", illegalOp, 1'b0);
        reset = 1'b0;

        // single add with last
        items = {};
        items.push_back(mk(4'd2, 4'd1, 4'd2, 4'd3, 4'd0, 1'b1));
        run_session(1'b1, 1'b0);

        // lw then bne back-to-back
        items = {};
        items.push_back(mk(4'd8, 4'd4, 4'd5, 4'd0, 4'd9, 1'b0));
        items.push_back(mk(4'd14, 4'd1, 4'd2, 4'd0, 4'hF, 1'b1));
        run_session(1'b1, 1'b0);

        // five offered, no last: memory fill closes the session
        items = {};
        for (int i = 0; i < 5; i++) items.push_back(mk(4'd1, 4'(i), 4'(i + 1), 4'(i + 2), 4'd0, 1'b0));
        run_session(1'b1, 1'b0);

        // illegal opcode sandwiched between legal words
        items = {};
        items.push_back(mk(4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 1'b0));
        items.push_back(mk(4'd5, 4'd2, 4'd3, 4'd4, 4'd6, 1'b0));
        items.push_back(mk(4'd7, 4'd3, 4'd3, 4'd3, 4'd0, 1'b1));
        run_session(1'b1, 1'b0);

        // reset right after an accept: pending write dropped, no loadDone
        @(negedge clk);
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
        inValid = 1'b1; opCode = 4'd2; rs = 4'd1; rt = 4'd2; rd = 4'd3; inLast = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_we", imemWe, 1'b0);
        chk("mid_rst_rdy", inReady, 1'b0);
        chk("mid_rst_addr", imemAddr, 0);
        chk("mid_rst_data", imemWData, 0);
        chk("mid_rst_wcnt", wordCount, 0);
        chk("mid_rst_done", loadDone, 1'b0);
        @(negedge clk);
        inValid = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_we", imemWe, 1'b0);
            chk("post_rst_done", loadDone, 1'b0);
        end

        // loadStart poked during LOAD must be ignored
        items = {};
        for (int i = 0; i < 3; i++) items.push_back(mk(4'd6, 4'(i), 4'd7, 4'd8, 4'd1, i == 2));
        run_session(1'b0, 1'b1);

        for (int s = 0; s < 25; s++) begin
            int n;
            n = $urandom_range(1, 6);
            items = {};
            for (int i = 0; i < n; i++) begin
                logic [3:0] op;
                logic [3:0] legal_ops [8];
                legal_ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd10, 4'd14};
                op = ($urandom_range(1) == 0) ? legal_ops[$urandom_range(7)] : 4'($urandom);
                items.push_back(mk(op, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                                   (i == n - 1) || ($urandom_range(4) == 0)));
            end
            run_session(1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
